// File: rtl/bnn_act_packer.sv
// bnn_act_packer: packs serial neuron activation bits (LSB-first) into M-bit
// words and buffers them in a first-word-fall-through FIFO. The input side
// never stalls; when the FIFO is full a committed word is dropped and the
// sticky overflow flag records the loss.
module bnn_act_packer #(
    parameter int M     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    input  logic                         flush,
    output logic [M-1:0]                 word_out,
    output logic [7:0]                   word_len,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [7:0]                   bit_count,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic [M-1:0]  asm_q, asm_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [DEPTH-1:0][M-1:0] data_q, data_d;
    logic [DEPTH-1:0][7:0]   len_q, len_d;

    logic [M-1:0] acc_word;
    logic [7:0]   acc_cnt;
    logic         commit, full, empty, pop, push;

    // Fall-through read of the head entry; storage resets to zero so the
    // outputs read 0 while in reset.
    assign word_out   = data_q[rd_ptr_q[AW-1:0]];
    assign word_len   = len_q[rd_ptr_q[AW-1:0]];
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign word_valid = !empty;
    assign fill_level = FW'(wr_ptr_q - rd_ptr_q);
    assign bit_count  = cnt_q;
    assign overflow   = ovf_q;

    // Accept this cycle's bit first, then decide whether the word commits
    // (count reached M, or flush with something assembled) and where it goes.
    always_comb begin
        acc_word = asm_q;
        acc_cnt  = cnt_q;
        if (bit_valid) begin
            acc_word[cnt_q[CW-1:0]] = bit_in;
            acc_cnt                 = cnt_q + 8'd1;
        end
        commit = (acc_cnt == 8'(M)) || (flush && (acc_cnt != 8'd0));
        pop    = word_valid && word_ready;
        // A pop in the same cycle frees the slot the push needs.
        push   = commit && (!full || pop);

        asm_d    = commit ? '0 : acc_word;
        cnt_d    = commit ? 8'd0 : acc_cnt;
        ovf_d    = ovf_q || (commit && !push);
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        data_d   = data_q;
        len_d    = len_q;
        if (push) begin
            data_d[wr_ptr_q[AW-1:0]] = acc_word;
            len_d[wr_ptr_q[AW-1:0]]  = acc_cnt;
        end
    end

    // State registers; reset discards any partial word and all FIFO contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            len_q    <= '0;
        end else begin
            asm_q    <= asm_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            len_q    <= len_d;
        end
    end
endmodule

// File: tb/tb_bnn_act_packer.sv
// Bench for bnn_act_packer: directed vectors, a queue-based reference model
// checked every cycle, plus literal expectations at the key points.
module tb_bnn_act_packer;
    localparam int M     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_in = 1'b0, bit_valid = 1'b0, flush = 1'b0, word_ready = 1'b0;
    logic [M-1:0] word_out;
    logic [7:0]   word_len, bit_count;
    logic         word_valid, overflow;
    logic [$clog2(DEPTH+1)-1:0] fill_level;

    int passed = 0;
    int total  = 0;

    bnn_act_packer #(.M(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .flush(flush), .word_out(word_out), .word_len(word_len),
        .word_valid(word_valid), .word_ready(word_ready),
        .fill_level(fill_level), .bit_count(bit_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {len, word}, an assembly value and count.
    logic [M+7:0] mq[$];
    logic [M-1:0] m_asm;
    int           m_cnt;
    logic         m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_asm = '0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            bit m_pop, m_full, m_commit;
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && word_ready;
            if (bit_valid) begin
                m_asm[m_cnt] = bit_in;
                m_cnt++;
            end
            m_commit = (m_cnt == M) || (flush && m_cnt != 0);
            if (m_pop) void'(mq.pop_front());
            if (m_commit) begin
                if (m_full && !m_pop) m_ovf = 1'b1;
                else mq.push_back({8'(m_cnt), m_asm});
                m_asm = '0;
                m_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", 64'(word_valid), 64'(mq.size() > 0));
            chk("m_fill", 64'(fill_level), 64'(mq.size()));
            chk("m_cnt", 64'(bit_count), 64'(m_cnt));
            chk("m_ovf", 64'(overflow), 64'(m_ovf));
            if (mq.size() > 0) begin
                chk("m_word", 64'(word_out), 64'(mq[0][M-1:0]));
                chk("m_len", 64'(word_len), 64'(mq[0][M+7:M]));
            end
        end
    end

    task automatic cyc(input logic b, input logic v, input logic f, input logic r);
        bit_in = b; bit_valid = v; flush = f; word_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [M-1:0] w, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(w[i], 1'b1, 1'b0, r);
    endtask

    initial begin
        #12;
        chk("rst_valid", 64'(word_valid), 64'd0);
        chk("rst_word", 64'(word_out), 64'd0);
        chk("rst_len", 64'(word_len), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Full word, consumer always ready
        send_bits(16'hA5C3, 16, 1'b1);
        chk("full_valid", 64'(word_valid), 64'd1);
        chk("full_word", 64'(word_out), 64'hA5C3);
        chk("full_len", 64'(word_len), 64'd16);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("full_popped", 64'(fill_level), 64'd0);

        // Partial word by flush; second flush is a no-op
        send_bits(16'h001D, 5, 1'b0);
        chk("part_cnt", 64'(bit_count), 64'd5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_word", 64'(word_out), 64'h001D);
        chk("flush_len", 64'(word_len), 64'd5);
        chk("flush_cnt", 64'(bit_count), 64'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_noop", 64'(fill_level), 64'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Bit and flush in the same cycle
        send_bits(16'h0000, 3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("bf_len", 64'(word_len), 64'd4);
        chk("bf_word", 64'(word_out), 64'h0008);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow: five words into four slots, then drain
        for (int k = 1; k <= 5; k++) send_bits(16'(k * 16'h1111), 16, 1'b0);
        chk("ovf_fill", 64'(fill_level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'(word_out), 64'h1111);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_fill", 64'(fill_level), 64'd0);
        chk("drain_ovf", 64'(overflow), 64'd1);

        // Asynchronous reset with 2 words stored and 9 bits assembled
        send_bits(16'h1234, 16, 1'b0);
        send_bits(16'h5678, 16, 1'b0);
        send_bits(16'h01FF, 9, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(word_valid), 64'd0);
        chk("arst_word", 64'(word_out), 64'd0);
        chk("arst_fill", 64'(fill_level), 64'd0);
        chk("arst_cnt", 64'(bit_count), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        send_bits(16'hBEEF, 16, 1'b0);
        chk("post_rst_word", 64'(word_out), 64'hBEEF);
        chk("post_rst_len", 64'(word_len), 64'd16);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Full FIFO, last bit of a new word coincides with a pop
        for (int k = 1; k <= 4; k++) send_bits(16'(k * 16'h0101), 16, 1'b0);
        send_bits(16'hC0DE, 15, 1'b0);
        chk("sim_pre_fill", 64'(fill_level), 64'd4);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sim_fill", 64'(fill_level), 64'd4);
        chk("sim_ovf", 64'(overflow), 64'd0);
        chk("sim_head", 64'(word_out), 64'h0202);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sim_drain", 64'(fill_level), 64'd0);

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bnn_act_packer.md
# bnn_act_packer

Downstream stage of the binary neuron unit: collects the serial one-bit neuron activations (bit plus valid strobe) into packed M-bit activation words. Completed words are buffered in a small first-word-fall-through FIFO and presented to the next layer's input register over a valid/ready handshake. The neuron stage cannot be back-pressured, so the packer never stalls its input. It drops whole words on overflow and reports the loss through a sticky flag.

## Interface
- M, 16: activation bits per packed word (2..64)
- DEPTH, 4: FIFO entries, power of two (2..16)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- bit_in  in  1  neuron activation bit
- bit_valid  in  1  bit_in is valid this cycle (driven by neuron valid_out)
- flush  in  1  commit the partial word currently being assembled
- word_out  out  M  head-of-FIFO packed word
- word_len  out  8  number of meaningful bits in word_out (1..M)
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts word_out this cycle
- fill_level  out  $clog2(DEPTH+1)  words currently stored
- bit_count  out  8  bits held in the assembly register (0..M-1)
- overflow  out  1  sticky: at least one word was dropped

## Operation
- Assembly register: shift-in LSB-first. The k-th accepted bit since the last commit lands in bit k. Unfilled bits are 0.
- bit_valid=1: the bit is accepted unconditionally and bit_count increments.
- Commit on full: when the accepted bit makes the count reach M, the word (len M) is committed that same edge. The assembly register and bit_count clear to 0.
- Commit on flush: flush=1 with a non-zero count after this cycle's accept commits the partial word, zero-padded, with len = count.
  - flush and bit_valid in the same cycle: the bit is included first, then the word is committed.
  - flush with count 0 and no bit_valid: no-op.
- Push: a committed word is written with its len into the FIFO.
  - FIFO full and no pop this cycle: the word is dropped, overflow is set to 1, and the assembly register still clears.
  - FIFO full with a simultaneous pop: the push succeeds.
- Pop: on word_valid & word_ready, rd_ptr advances. word_ready while word_valid=0 has no effect.
- fill_level = pushes − pops. A simultaneous push and pop leaves it unchanged.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full is when the MSBs differ and the low bits are equal; empty is when the pointers are equal.
- overflow clears only on rst.

## Timing
- Reset state, asserted asynchronously: word_out=0, word_len=0, word_valid=0, fill_level=0, bit_count=0, overflow=0. FIFO storage and pointers are 0.
- word_out and word_len are read combinationally from FIFO storage at rd_ptr (first-word fall-through). They hold stable while word_valid=1 and word_ready=0.
- Latency: the edge that accepts the M-th bit (or the flush) makes the word visible on word_valid, word_out and word_len after that edge, i.e. one cycle. This holds only if the FIFO was empty.
- Throughput: one bit per cycle in. One word per cycle out when word_ready is held high.
- Reset mid-word or with a non-empty FIFO: all contents are discarded with no partial output. The first bit after rst deasserts is bit 0 of a fresh word.
- bit_count and fill_level are registered and reflect state after the last edge.

## Test plan
- M=16, DEPTH=4, word_ready=1, 16 consecutive bits of pattern 0xA5C3 LSB-first → one cycle after the 16th bit: word_valid=1, word_out=0xA5C3, word_len=16. Word popped next edge, fill_level returns to 0.
- 5 bits 1,0,1,1,1 then flush alone → word_out=0x001D, word_len=5, bit_count=0. A second flush with no bits produces no word.
- 3 bits, then a 4th bit with flush in the same cycle (bit=1) → word_len=4, word_out[3]=1.
- word_ready=0, 5 full words pushed → fill_level=4, overflow=1, and the stored words are words 1–4 unchanged. Then word_ready=1 drains 4 words in 4 cycles; overflow stays 1.
- FIFO full, the 16th bit of a new word arrives in the same cycle as a pop → no drop, overflow stays 0, fill_level stays 4.
- rst asserted asynchronously with 9 bits assembled and 2 words stored → all outputs 0 immediately. The next 16 bits after release produce a word that starts at bit 0.
